// File: rtl/fingerprint_scan_controller_pkg.sv
// ---------------------------------------------------------------------------
// fp_attend_pkg
// Shared definitions for the fingerprint scan controller slice:
//   - ID_W           : width of a fingerprint ID
//   - NO_FINGER_ID   : reserved ID meaning "no finger on the sensor"
//   - state_e        : controller FSM states
//   - EMP1..EMP3     : well-known employee IDs
// No ports (package).
// ---------------------------------------------------------------------------
package fp_attend_pkg;

  localparam int ID_W = 3;

  localparam logic [ID_W-1:0] NO_FINGER_ID = '0;

  localparam logic [ID_W-1:0] EMP1 = 3'd1;
  localparam logic [ID_W-1:0] EMP2 = 3'd2;
  localparam logic [ID_W-1:0] EMP3 = 3'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    WAIT    = 2'd2,
    REPORT  = 2'd3
  } state_e;

endpackage

// File: rtl/fingerprint_scan_controller_if.sv
// ---------------------------------------------------------------------------
// fingerprint_scan_controller_if
// Bundles the sensor, verifier and result-side signals of the controller.
//   slave  modport : the controller's view (sensor/verifier inputs in,
//                    verifier drive and result outputs out)
//   master modport : the environment's view (sensor, verifier, display)
// Signals:
//   day_clear, on_time, sensor_valid, sensor_id, attendance_accepted
//   sensor_ready, fingerprint, attend_flag, verify_on_time,
//   result_valid, result_accepted, result_duplicate, attend_count
// ---------------------------------------------------------------------------
interface fingerprint_scan_controller_if #(
  parameter int IDW = fp_attend_pkg::ID_W
);

  logic           day_clear;
  logic           on_time;
  logic           sensor_valid;
  logic [IDW-1:0] sensor_id;
  logic           sensor_ready;
  logic           attendance_accepted;
  logic [IDW-1:0] fingerprint;
  logic           attend_flag;
  logic           verify_on_time;
  logic           result_valid;
  logic           result_accepted;
  logic           result_duplicate;
  logic [IDW:0]   attend_count;

  modport slave (
    input  day_clear, on_time, sensor_valid, sensor_id, attendance_accepted,
    output sensor_ready, fingerprint, attend_flag, verify_on_time,
           result_valid, result_accepted, result_duplicate, attend_count
  );

  modport master (
    output day_clear, on_time, sensor_valid, sensor_id, attendance_accepted,
    input  sensor_ready, fingerprint, attend_flag, verify_on_time,
           result_valid, result_accepted, result_duplicate, attend_count
  );

endinterface

// File: rtl/fingerprint_scan_controller_bitmap.sv
// ---------------------------------------------------------------------------
// fp_attend_bitmap
// Per-employee "already attended" register, one bit per ID.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   rd_idx_i       : read address
//   rd_bit_o       : bit at rd_idx_i (combinational)
//   set_i/set_idx_i: set the bit at set_idx_i
//   clear_i        : clear every bit; takes priority over set_i
// ---------------------------------------------------------------------------
module fp_attend_bitmap #(
  parameter int NUM_EMP = 8,
  parameter int IDW     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IDW-1:0] rd_idx_i,
  output logic           rd_bit_o,
  input  logic           set_i,
  input  logic [IDW-1:0] set_idx_i,
  input  logic           clear_i
);

  logic [NUM_EMP-1:0] bits_q;

  // Clear-all beats set so a day rollover never leaves a stale bit behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits_q <= '0;
    end else if (clear_i) begin
      bits_q <= '0;
    end else if (set_i) begin
      bits_q[set_idx_i] <= 1'b1;
    end
  end

  assign rd_bit_o = bits_q[rd_idx_i];

endmodule

// File: rtl/fingerprint_scan_controller.sv
// ---------------------------------------------------------------------------
// fingerprint_scan_controller
// Front end for the fingerprint attendance verifier: takes one scan from the
// sensor, presents the ID and its attended bit to the verifier, waits up to
// RESP_WAIT cycles for an accept, updates the attended bitmap and reports one
// result pulse per scan.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fingerprint_scan_controller_if.slave (sensor, verifier,
//                result and attend_count signals)
// Optional build macro ATTEND_COUNT_EN: when defined, attend_count counts
// accepted results (saturating at NUM_EMP, cleared by day_clear); otherwise
// attend_count is tied to 0.
// ---------------------------------------------------------------------------
module fingerprint_scan_controller
  import fp_attend_pkg::*;
#(
  parameter int NUM_EMP   = 8,
  parameter int RESP_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  fingerprint_scan_controller_if.slave bus
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   fp_q, fp_d;
  logic              flag_q, flag_d;
  logic              acc_q, acc_d;
  logic [3:0]        wait_q, wait_d;
  logic              vot_q;
  logic              set_en;
  logic              rd_bit;
  logic [ID_W:0]     count_q;

  fp_attend_bitmap #(
    .NUM_EMP (NUM_EMP),
    .IDW     (ID_W)
  ) u_bitmap (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (bus.sensor_id),
    .rd_bit_o  (rd_bit),
    .set_i     (set_en),
    .set_idx_i (fp_q),
    .clear_i   (bus.day_clear)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fp_q    <= NO_FINGER_ID;
      flag_q  <= 1'b0;
      acc_q   <= 1'b0;
      wait_q  <= '0;
      vot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      flag_q  <= flag_d;
      acc_q   <= acc_d;
      wait_q  <= wait_d;
      vot_q   <= bus.on_time;
    end
  end

  // The verifier's duplicate indication is the attend_flag latched at scan
  // time, so flag_q doubles as the recorded duplicate flag.
  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    flag_d  = flag_q;
    acc_d   = acc_q;
    wait_d  = wait_q;
    set_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        fp_d   = NO_FINGER_ID;
        flag_d = 1'b0;
        acc_d  = 1'b0;
        if (bus.sensor_valid) begin
          if (bus.sensor_id != NO_FINGER_ID) begin
            fp_d    = bus.sensor_id;
            flag_d  = rd_bit;
            state_d = PRESENT;
          end else begin
            state_d = REPORT;
          end
        end
      end
      PRESENT: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.attendance_accepted) begin
          set_en  = 1'b1;
          acc_d   = 1'b1;
          state_d = REPORT;
        end else if (wait_q == 4'(RESP_WAIT - 1)) begin
          acc_d   = 1'b0;
          state_d = REPORT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      REPORT: begin
        fp_d    = NO_FINGER_ID;
        flag_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ATTEND_COUNT_EN
  localparam logic [ID_W:0] CNT_MAX = (ID_W + 1)'(NUM_EMP);

  // day_clear wins over a coincident accept, matching the bitmap.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.day_clear) begin
      count_q <= '0;
    end else if (set_en && count_q != CNT_MAX) begin
      count_q <= count_q + 1'b1;
    end
  end
`else
  assign count_q = '0;
`endif

  assign bus.sensor_ready     = (state_q == IDLE);
  assign bus.fingerprint      = fp_q;
  assign bus.attend_flag      = flag_q;
  assign bus.verify_on_time   = vot_q;
  assign bus.result_valid     = (state_q == REPORT);
  assign bus.result_accepted  = (state_q == REPORT) && acc_q;
  assign bus.result_duplicate = (state_q == REPORT) && flag_q;
  assign bus.attend_count     = count_q;

endmodule

// File: doc/fingerprint_scan_controller.md
Name: fingerprint_scan_controller

Overview:
- Front-end driver for the fingerprint attendance verifier. It takes raw scans from the sensor and presents each ID on the verifier's fingerprint/attend-flag inputs.
- It collects the verifier's accept response and keeps the per-employee "already attended" bitmap that feeds the verifier's attendFlag input.
- It reports one result per scan to the display/logging side.

Parameters:
- ID_W, 3, width of the fingerprint ID; ID 0 is reserved as "no finger" and is never valid.
- NUM_EMP, 8, number of bitmap entries; must equal 2**ID_W.
- RESP_WAIT, 2, cycles the controller waits for attendance_accepted before declaring a reject; range 1..15.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- day_clear, in, 1, single-cycle pulse; clears the attended bitmap.
- on_time, in, 1, attendance window open; passed through to the verifier.
- sensor_valid, in, 1, sensor has a new scan this cycle.
- sensor_id, in, ID_W, scanned ID, qualified by sensor_valid.
- sensor_ready, out, 1, controller can accept a scan (high only in IDLE).
- attendance_accepted, in, 1, verifier response.
- fingerprint, out, ID_W, ID driven to the verifier.
- attend_flag, out, 1, bitmap bit for the presented ID, driven to the verifier.
- verify_on_time, out, 1, registered copy of on_time, driven to the verifier.
- result_valid, out, 1, one-cycle pulse per completed scan.
- result_accepted, out, 1, attendance recorded; valid with result_valid.
- result_duplicate, out, 1, employee had already attended; valid with result_valid.
- attend_count, out, ID_W+1, number of employees recorded today (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; bitmap cleared.
  - fingerprint=0, attend_flag=0, verify_on_time=0.
  - result_valid, result_accepted, result_duplicate=0; attend_count=0.
  - sensor_ready=1 on the first cycle after reset is released.
  - Reset mid-scan aborts the scan with no result pulse.
- FSM states are IDLE, PRESENT, WAIT and REPORT.
- IDLE:
  - fingerprint is held at 0, so back-to-back scans of the same ID always present a value change to the verifier.
  - On sensor_valid with sensor_id≠0: latch the ID into the fingerprint register, latch its bitmap bit into attend_flag, go to PRESENT.
  - On sensor_valid with sensor_id=0: go directly to REPORT with accepted=0 and duplicate=0.
- PRESENT: one cycle for the verifier's response to settle; clear the wait counter; go to WAIT.
- WAIT:
  - Sample attendance_accepted every cycle.
  - If it is 1: set the bitmap bit for the ID, record accepted=1, go to REPORT.
  - If it is still 0 after RESP_WAIT cycles: record accepted=0, go to REPORT.
  - duplicate is recorded as attend_flag.
- REPORT:
  - Drive result_valid=1 for exactly one cycle with the recorded flags.
  - Return fingerprint and attend_flag to 0; go to IDLE.
- Latency: result_valid asserts exactly 3 cycles after the sensor_valid cycle when the accept arrives on the first WAIT cycle. Worst case is 2+RESP_WAIT cycles.
- sensor_valid outside IDLE is ignored; the sensor must hold its scan until sensor_ready.
- The verifier rejects when on_time=0. The controller does not gate on on_time itself and reports the reject normally.
- day_clear:
  - Clears the bitmap and attend_count in the cycle it is sampled.
  - If it coincides with a WAIT accept: the clear wins, the bitmap ends all-zero, and the result is still reported as accepted.
- attend_count increments by one per accepted result and saturates at NUM_EMP.

Optional Feature:
- Macro: ATTEND_COUNT_EN.
- Defined: attend_count is implemented as described above.
- Undefined: the counter is not built and attend_count is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package fp_attend_pkg holds:
  - ID_W and the reserved NO_FINGER_ID=0.
  - The state enum (IDLE, PRESENT, WAIT, REPORT).
  - Employee ID constants EMP1=1, EMP2=2, EMP3=3.
- One sub-module, fp_attend_bitmap: NUM_EMP-bit register with read port, set port and clear-all port, where clear-all has priority over set.

Test Plan:
- Reset, then scan ID 1 with on_time=1 and the verifier answering 1 on the first WAIT cycle → result_valid exactly 3 cycles later; accepted=1, duplicate=0; bitmap[1]=1; attend_count=1.
- Scan ID 1 a second time → attend_flag=1 during PRESENT; the verifier rejects; result shows accepted=0, duplicate=1 after 2+RESP_WAIT cycles; attend_count stays 1.
- Scan ID 5 (unknown), verifier returns 0 → reject after RESP_WAIT timeout; bitmap[5]=0.
- sensor_id=0 with sensor_valid → result_valid on the next cycle with accepted=0; fingerprint never leaves 0.
- day_clear pulsed in the same cycle as an accept for ID 2 → bitmap all-zero afterwards; result reported with accepted=1; a rescan of ID 2 shows duplicate=0.
- rst_n low during WAIT → no result_valid; the next cycle shows all outputs at reset values; a new scan of ID 3 completes normally.
